// File: rtl/prng_pkg.sv
// Shared definitions for the 8-bit XNOR-feedback PRBS generator and checker.
package prng_pkg;

    localparam int LFSR_W = 8;
    localparam logic [LFSR_W-1:0] TAP_MASK = 8'b1100_1101;

    typedef enum logic [1:0] {
        SEED,
        VERIFY,
        LOCKED
    } state_t;

    function automatic logic lfsr_fb(input logic [LFSR_W-1:0] r);
        return ~^(r & TAP_MASK);
    endfunction

endpackage

// File: rtl/prbs_err_window.sv
// Sliding error-density monitor: counts errors over fixed windows of step pulses
// and flags the step on which the error count reaches the limit.
module prbs_err_window #(
    parameter int ERR_WIN   = 64,
    parameter int ERR_LIMIT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic step,
    input  logic err,
    input  logic clear,
    output logic limit_hit
);

    localparam int WIN_W = $clog2(ERR_WIN + 1);
    localparam int ERR_W = $clog2(ERR_LIMIT + 1);

    logic [WIN_W-1:0] r_win;
    logic [ERR_W-1:0] r_werr;
    logic [ERR_W-1:0] w_werr_next;

    // The current bit counts toward the limit before the window wraps.
    assign w_werr_next = r_werr + ERR_W'(err);
    assign limit_hit   = step && err && (w_werr_next == ERR_W'(ERR_LIMIT));

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            r_win  <= '0;
            r_werr <= '0;
        end else if (step) begin
            if (r_win == WIN_W'(ERR_WIN - 1)) begin
                r_win  <= '0;
                r_werr <= '0;
            end else begin
                r_win  <= r_win + WIN_W'(1);
                r_werr <= w_werr_next;
            end
        end
    end

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising checker for the 8-bit XNOR PRBS: hunts, verifies, then
// free-runs its LFSR while counting mismatches and dropping lock on error bursts.
module prbs_checker
    import prng_pkg::*;
#(
    parameter int LOCK_CNT  = 16,
    parameter int ERR_WIN   = 64,
    parameter int ERR_LIMIT = 8,
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 din,
    input  logic                 din_valid,
    input  logic                 clr_cnt,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int FILL_W  = $clog2(LFSR_W);
    localparam int MATCH_W = $clog2(LOCK_CNT + 1);

    state_t               r_state;
    logic [LFSR_W-1:0]    r_lfsr;
    logic [FILL_W-1:0]    r_fill;
    logic [MATCH_W-1:0]   r_match;
    logic                 r_locked;
    logic                 r_err_pulse;
    logic [ERR_CNT_W-1:0] r_err_count;

    logic w_pred;
    logic w_mismatch;
    logic w_win_step;
    logic w_win_clear;
    logic w_limit_hit;

    assign w_pred      = lfsr_fb(r_lfsr);
    assign w_mismatch  = din ^ w_pred;
    assign w_win_step  = din_valid && (r_state == LOCKED);
    assign w_win_clear = (r_state != LOCKED);

    prbs_err_window #(
        .ERR_WIN   (ERR_WIN),
        .ERR_LIMIT (ERR_LIMIT)
    ) u_err_window (
        .clk       (clk),
        .reset     (reset),
        .step      (w_win_step),
        .err       (w_mismatch),
        .clear     (w_win_clear),
        .limit_hit (w_limit_hit)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= SEED;
            r_lfsr      <= '0;
            r_fill      <= '0;
            r_match     <= '0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_err_pulse <= 1'b0;
            if (din_valid) begin
                case (r_state)
                    SEED: begin
                        r_lfsr <= {r_lfsr[LFSR_W-2:0], din};
                        if (r_fill == FILL_W'(LFSR_W - 1)) begin
                            r_fill  <= '0;
                            r_match <= '0;
                            r_state <= VERIFY;
                        end else begin
                            r_fill <= r_fill + FILL_W'(1);
                        end
                    end
                    VERIFY: begin
                        r_lfsr <= {r_lfsr[LFSR_W-2:0], din};
                        if (w_mismatch) begin
                            r_fill  <= '0;
                            r_match <= '0;
                            r_state <= SEED;
                        end else if (r_match == MATCH_W'(LOCK_CNT - 1)) begin
                            r_match  <= '0;
                            r_locked <= 1'b1;
                            r_state  <= LOCKED;
                        end else begin
                            r_match <= r_match + MATCH_W'(1);
                        end
                    end
                    LOCKED: begin
                        // Shift the prediction, not din, so a bad bit cannot corrupt the model.
                        r_lfsr <= {r_lfsr[LFSR_W-2:0], w_pred};
                        if (w_mismatch) begin
                            r_err_pulse <= 1'b1;
                            if (r_err_count != '1) begin
                                r_err_count <= r_err_count + ERR_CNT_W'(1);
                            end
                        end
                        if (w_limit_hit) begin
                            r_locked <= 1'b0;
                            r_fill   <= '0;
                            r_state  <= SEED;
                        end
                    end
                    default: begin
                        r_fill   <= '0;
                        r_match  <= '0;
                        r_locked <= 1'b0;
                        r_state  <= SEED;
                    end
                endcase
            end
            if (clr_cnt) begin
                r_err_count <= '0;
            end
        end
    end

    assign locked    = r_locked;
    assign err_pulse = r_err_pulse;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed/randomised bench for prbs_checker against a recurrence-based stream model.
module tb_prbs_checker;

    localparam int CW     = 4;
    localparam int CNTMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          din = 1'b0;
    logic          din_valid = 1'b0;
    logic          clr_cnt = 1'b0;
    logic          locked;
    logic          err_pulse;
    logic [CW-1:0] err_count;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_cnt = 0;
    bit gq[$];

    prbs_checker #(
        .LOCK_CNT  (16),
        .ERR_WIN   (64),
        .ERR_LIMIT (8),
        .ERR_CNT_W (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_valid (din_valid),
        .clr_cnt   (clr_cnt),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    // Stream recurrence: s[n] = ~(s[n-1]^s[n-3]^s[n-4]^s[n-7]^s[n-8]), s[<0] = 0.
    function automatic bit tap(input int k);
        int i;
        i = gq.size() - k;
        return (i >= 0) ? gq[i] : 1'b0;
    endfunction

    function automatic bit pred_next();
        return ~(tap(1) ^ tap(3) ^ tap(4) ^ tap(7) ^ tap(8));
    endfunction

    function automatic bit gen_next();
        bit b;
        b = pred_next();
        gq.push_back(b);
        return b;
    endfunction

    function automatic int sat_inc(input int c);
        return (c >= CNTMAX) ? CNTMAX : c + 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic d, input logic v, input logic c);
        din = d;
        din_valid = v;
        clr_cnt = c;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic l, input logic p);
        check({tag, ".locked"}, 32'(locked), 32'(l));
        check({tag, ".err_pulse"}, 32'(err_pulse), 32'(p));
        check({tag, ".err_count"}, 32'(err_count), 32'(exp_cnt));
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b0;
        repeat (cycles) drive(1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        gq.delete();
        exp_cnt = 0;
    endtask

    initial begin
        int vidx;
        int l_idx;
        int e_pos[8];
        int seed_start;
        bit b;
        bit inv;
        bit v;

        // Error-free lock from the all-zero generator state.
        do_reset(2);
        expect_out("reset", 1'b0, 1'b0);
        for (int n = 1; n <= 1000; n++) begin
            b = gen_next();
            drive(b, 1'b1, 1'b0);
            expect_out("clean", n >= 24, 1'b0);
        end

        // Gapped valid with junk on invalid cycles.
        do_reset(1);
        vidx = 0;
        for (int c = 0; vidx < 30 && c < 200; c++) begin
            v = (c % 3 == 0);
            if (v) begin
                vidx++;
                b = gen_next();
            end else begin
                b = 1'($urandom);
            end
            drive(b, v, 1'b0);
            expect_out("gapped", vidx >= 24, 1'b0);
        end
        check("gapped.reached", 32'(vidx), 32'd30);

        // Single inverted bit #100, then 200 clean bits.
        for (int c = 0; vidx < 300 && c < 2000; c++) begin
            v = ($urandom_range(0, 3) != 0);
            inv = 1'b0;
            b = 1'($urandom);
            if (v) begin
                vidx++;
                b = gen_next();
                inv = (vidx == 100);
                if (inv) exp_cnt = sat_inc(exp_cnt);
            end
            drive(b ^ inv, v, 1'b0);
            expect_out("single", 1'b1, inv);
        end
        check("single.count", 32'(err_count), 32'd1);

        // Eight errors inside the window starting at valid bit 345 (lock at 24).
        for (int i = 0; i < 8; i++) e_pos[i] = 345 + i * 7 + int'($urandom_range(0, 6));
        l_idx = e_pos[7];
        for (int c = 0; vidx < l_idx + 40 && c < 2000; c++) begin
            v = ($urandom_range(0, 3) != 0);
            inv = 1'b0;
            b = 1'($urandom);
            if (v) begin
                vidx++;
                b = gen_next();
                for (int i = 0; i < 8; i++) if (e_pos[i] == vidx) inv = 1'b1;
                if (inv) exp_cnt = sat_inc(exp_cnt);
            end
            drive(b ^ inv, v, 1'b0);
            expect_out("burst", (vidx < l_idx) || (vidx >= l_idx + 24), inv);
        end
        check("burst.count", 32'(err_count), 32'd9);

        // Random data; any window that would happen to verify is broken on its last bit.
        do_reset(1);
        seed_start = 0;
        for (int n = 0; n < 5000; n++) begin
            b = 1'($urandom);
            if (n - seed_start >= 8) begin
                if (n - seed_start == 23 && b == pred_next()) b = ~b;
                if (b != pred_next()) seed_start = n + 1;
            end
            gq.push_back(b);
            drive(b, 1'b1, 1'b0);
            expect_out("random", 1'b0, 1'b0);
        end

        // Clear coincident with an error, then saturation, then reset while locked.
        do_reset(1);
        for (int n = 1; n <= 300; n++) begin
            b = gen_next();
            inv = (n == 30) || (n == 40);
            for (int w = 1; w <= 3; w++) begin
                for (int k = 0; k < 6; k++) begin
                    if (n == 25 + 64 * w + 2 + 9 * k) inv = 1'b1;
                end
            end
            if (inv) exp_cnt = sat_inc(exp_cnt);
            if (n == 40) exp_cnt = 0;
            drive(b ^ inv, 1'b1, n == 40);
            expect_out("clrsat", n >= 24, inv);
        end
        check("clrsat.saturated", 32'(err_count), 32'(CNTMAX));
        reset = 1'b0;
        b = gen_next();
        drive(b, 1'b1, 1'b0);
        exp_cnt = 0;
        expect_out("midreset", 1'b0, 1'b0);
        reset = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            b = gen_next();
            drive(b, 1'b1, 1'b0);
            expect_out("relock", n >= 24, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
